mem_arbiter: RTL and testbench

Shares one single-port synchronous RAM (1-cycle read latency) between the 6502 CPU bus and the floppy DMA engine. The CPU has default priority. DMA gets idle CPU cycles, and after a bounded wait it forces one stolen cycle by stalling the CPU through cpu_rdy. The block sits between chip_6502 (address/data_out/rw), the floppy DMA port and the RAM macro.

---
 rtl/mem_bus_pkg.sv | 33 +++
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter_wait_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 96 +++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_bus_pkg                                                      |
// | Shared widths, read-owner encoding and RAM latency for the       |
// | CPU/DMA memory arbiter.                                          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_bus_pkg;

    localparam int AW_DEFAULT     = 16;
    localparam int DW_DEFAULT     = 8;
    localparam int RAM_RD_LATENCY = 1;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_CPU  = 2'd1;
    localparam owner_t OWN_DMA  = 2'd2;

    function automatic owner_t read_owner(input logic cpu_win, input logic cpu_rw,
                                          input logic dma_win, input logic dma_rw);
        owner_t own;
        own = OWN_NONE;
        if (dma_win && dma_rw) begin
            own = OWN_DMA;
        end else if (cpu_win && cpu_rw) begin
            own = OWN_CPU;
        end
        return own;
    endfunction

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_if                                                   |
// | CPU bus, floppy DMA port and RAM macro signals of the arbiter.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mem_arbiter_if
    import mem_bus_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_rw;
    logic          cpu_rdy;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_rw;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_rw,
        output cpu_rdy, cpu_rdata,
        input  dma_req, dma_addr, dma_wdata, dma_rw,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Masters plus RAM side
    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_rw,
        input  cpu_rdy, cpu_rdata,
        output dma_req, dma_addr, dma_wdata, dma_rw,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter_wait_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arb_wait_counter                                                 |
// | Counts contested cycles lost by DMA; raises force_gnt at limit.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module arb_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  wire  clk,
    input  wire  rstn,
    input  wire  dma_req,
    input  wire  cpu_win,
    input  wire  dma_gnt,
    output logic force_gnt
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wait_cnt <= 4'd0;
        end else if (dma_gnt || !dma_req) begin
            r_wait_cnt <= 4'd0;
        end else if (cpu_win && (r_wait_cnt != c_max_wait)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign force_gnt = (r_wait_cnt == c_max_wait);

endmodule : arb_wait_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter                                                      |
// | Shares one 1-cycle-latency RAM between the 6502 bus and floppy   |
// | DMA; CPU has priority, DMA gets idle or forced stolen cycles.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int AW           = AW_DEFAULT,
    parameter int DW           = DW_DEFAULT,
    parameter int DMA_MAX_WAIT = 4
) (
    input wire           clk,
    input wire           rstn,
    mem_arbiter_if.slave bus
);

    logic   w_force;
    logic   w_dma_win;
    logic   w_cpu_win;
    owner_t w_rd_issue;

    owner_t        r_rd_pipe [RAM_RD_LATENCY];
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dma_rdata;
    logic          r_dma_rvalid;

    arb_wait_counter #(
        .MAX_WAIT (DMA_MAX_WAIT)
    ) u_wait_counter (
        .clk       (clk),
        .rstn      (rstn),
        .dma_req   (bus.dma_req),
        .cpu_win   (w_cpu_win),
        .dma_gnt   (w_dma_win),
        .force_gnt (w_force)
    );

    // Gating with rstn keeps every grant and strobe quiet during reset.
    assign w_dma_win  = rstn & bus.dma_req & (~bus.cpu_req | w_force);
    assign w_cpu_win  = rstn & bus.cpu_req & ~w_dma_win;
    assign w_rd_issue = read_owner(w_cpu_win, bus.cpu_rw, w_dma_win, bus.dma_rw);

    always_comb begin
        bus.cpu_rdy   = ~(bus.cpu_req & w_dma_win);
        bus.dma_gnt   = w_dma_win;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        if (!rstn) begin
            bus.mem_addr  = '0;
            bus.mem_wdata = '0;
        end else if (w_dma_win) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = ~bus.dma_rw;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end else if (w_cpu_win) begin
            bus.mem_en = 1'b1;
            bus.mem_we = ~bus.cpu_rw;
        end
    end

    // The last pipe stage names who owns the data now on mem_rdata.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < RAM_RD_LATENCY; i++) begin
                r_rd_pipe[i] <= OWN_NONE;
            end
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_rd_pipe[0] <= w_rd_issue;
            for (int i = 1; i < RAM_RD_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            r_dma_rvalid <= (r_rd_pipe[RAM_RD_LATENCY-1] == OWN_DMA);
            if (r_rd_pipe[RAM_RD_LATENCY-1] == OWN_CPU) begin
                r_cpu_rdata <= bus.mem_rdata;
            end
            if (r_rd_pipe[RAM_RD_LATENCY-1] == OWN_DMA) begin
                r_dma_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.dma_rdata  = r_dma_rdata;
    assign bus.dma_rvalid = r_dma_rvalid;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter                                                   |
// | Directed and random bench for mem_arbiter with a RAM model and a |
// | transaction-level reference.                                     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(16), .DW(8)) bus ();

    mem_arbiter #(
        .AW           (16),
        .DW           (8),
        .DMA_MAX_WAIT (MAXW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // RAM macro model: synchronous, one cycle read latency
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        bit         is_dma;
        logic [7:0] data;
        int         age;
    } rd_t;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] shadow [0:65535];
    rd_t        rd_q[$];
    int         dma_waited = 0;
    logic [7:0] exp_cpu_rdata = 8'h00;
    logic [7:0] exp_dma_rdata = 8'h00;
    logic       exp_dma_rvalid = 1'b0;
    logic       last_gnt = 1'b0;
    logic       last_rdy = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic [15:0] a, input logic [7:0] d, input logic rw);
        bus.cpu_req = req; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_rw = rw;
    endtask

    task automatic set_dma(input logic req, input logic [15:0] a, input logic [7:0] d, input logic rw);
        bus.dma_req = req; bus.dma_addr = a; bus.dma_wdata = d; bus.dma_rw = rw;
    endtask

    // One clock: check the combinational decision, advance the model, check registers.
    task automatic step(input logic rn);
        logic        e_gnt, e_rdy, e_en, e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        bit          dma_turn;
        rd_t         ent;
        rstn = rn;
        #3;
        dma_turn = bus.dma_req && (!bus.cpu_req || dma_waited >= MAXW);
        e_gnt = 1'b0; e_rdy = 1'b1; e_en = 1'b0; e_we = 1'b0;
        e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata;
        if (!rn) begin
            e_addr = 16'h0; e_wd = 8'h0;
        end else if (dma_turn) begin
            e_gnt = 1'b1; e_rdy = !bus.cpu_req; e_en = 1'b1; e_we = !bus.dma_rw;
            e_addr = bus.dma_addr; e_wd = bus.dma_wdata;
        end else if (bus.cpu_req) begin
            e_en = 1'b1; e_we = !bus.cpu_rw;
        end
        check("dma_gnt", bus.dma_gnt, e_gnt);
        check("cpu_rdy", bus.cpu_rdy, e_rdy);
        check("mem_en", bus.mem_en, e_en);
        check("mem_we", bus.mem_we, e_we);
        check("mem_addr", bus.mem_addr, e_addr);
        if (!rn || e_we) check("mem_wdata", bus.mem_wdata, e_wd);
        last_gnt = bus.dma_gnt;
        last_rdy = bus.cpu_rdy;
        if (e_en) begin
            if (e_we) shadow[e_addr] = e_wd;
            else      rd_q.push_back('{dma_turn, shadow[e_addr], 0});
        end
        if (!rn || !bus.dma_req || dma_turn) dma_waited = 0;
        else if (bus.cpu_req)                 dma_waited++;

        @(posedge clk);
        #1;
        exp_dma_rvalid = 1'b0;
        if (!rn) begin
            rd_q.delete();
            exp_cpu_rdata = 8'h00;
            exp_dma_rdata = 8'h00;
        end else begin
            foreach (rd_q[i]) rd_q[i].age++;
            if (rd_q.size() > 0 && rd_q[0].age >= 2) begin
                ent = rd_q.pop_front();
                if (ent.is_dma) begin
                    exp_dma_rvalid = 1'b1;
                    exp_dma_rdata  = ent.data;
                end else begin
                    exp_cpu_rdata = ent.data;
                end
            end
        end
        check("cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
        check("dma_rvalid", bus.dma_rvalid, exp_dma_rvalid);
        check("dma_rdata", bus.dma_rdata, exp_dma_rdata);
    endtask

    initial begin
        rstn = 1'b0;
        set_cpu(1'b1, 16'h0200, 8'h00, 1'b1);
        set_dma(1'b1, 16'h1000, 8'h00, 1'b1);

        // Reset with both masters requesting
        for (int i = 0; i < 3; i++) step(1'b0);
        check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        check("rst_dma_rvalid", bus.dma_rvalid, 1'b0);

        // CPU only: write then read back
        set_dma(1'b0, 16'h0000, 8'h00, 1'b1);
        set_cpu(1'b1, 16'h0200, 8'h5A, 1'b0);
        step(1'b1);
        check("cpu_wr_rdy", last_rdy, 1'b1);
        set_cpu(1'b1, 16'h0200, 8'h00, 1'b1);
        step(1'b1);
        set_cpu(1'b0, 16'h0200, 8'h00, 1'b1);
        step(1'b1);
        check("cpu_rd_0200", bus.cpu_rdata, 8'h5A);

        // Preload values used by the directed reads
        set_cpu(1'b1, 16'h1000, 8'hC3, 1'b0); step(1'b1);
        set_cpu(1'b1, 16'h0010, 8'h11, 1'b0); step(1'b1);
        set_cpu(1'b1, 16'h0020, 8'h22, 1'b0); step(1'b1);

        // DMA read in an idle CPU cycle
        set_cpu(1'b0, 16'h0000, 8'h00, 1'b1);
        set_dma(1'b1, 16'h1000, 8'h00, 1'b1);
        step(1'b1);
        check("dma_idle_gnt", last_gnt, 1'b1);
        set_dma(1'b0, 16'h1000, 8'h00, 1'b1);
        step(1'b1);
        check("dma_idle_rvalid", bus.dma_rvalid, 1'b1);
        check("dma_idle_rdata", bus.dma_rdata, 8'hC3);

        // Starvation: CPU busy every cycle, DMA forced every fifth cycle
        set_cpu(1'b1, 16'h0010, 8'h00, 1'b1);
        set_dma(1'b1, 16'h1000, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            check("starve_gnt", last_gnt, (i % 5) == 4);
            check("starve_rdy", last_rdy, (i % 5) != 4);
        end

        // Interleaved CPU then DMA reads
        set_dma(1'b0, 16'h0000, 8'h00, 1'b1);
        set_cpu(1'b1, 16'h0010, 8'h00, 1'b1);
        step(1'b1);
        set_cpu(1'b0, 16'h0000, 8'h00, 1'b1);
        set_dma(1'b1, 16'h0020, 8'h00, 1'b1);
        step(1'b1);
        check("ilv_cpu_rdata", bus.cpu_rdata, 8'h11);
        set_dma(1'b0, 16'h0000, 8'h00, 1'b1);
        step(1'b1);
        check("ilv_dma_rvalid", bus.dma_rvalid, 1'b1);
        check("ilv_dma_rdata", bus.dma_rdata, 8'h22);
        check("ilv_cpu_hold", bus.cpu_rdata, 8'h11);

        // Reset while a DMA read is in flight
        set_dma(1'b1, 16'h0020, 8'h00, 1'b1);
        step(1'b1);
        check("rstmid_gnt", last_gnt, 1'b1);
        set_dma(1'b0, 16'h0000, 8'h00, 1'b1);
        step(1'b0);
        check("rstmid_rvalid0", bus.dma_rvalid, 1'b0);
        step(1'b1);
        check("rstmid_rvalid1", bus.dma_rvalid, 1'b0);
        set_cpu(1'b1, 16'h0010, 8'h00, 1'b1);
        set_dma(1'b1, 16'h1000, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            check("rstmid_cnt_gnt", last_gnt, i == 4);
        end

        // Fill the random window so every later read is defined
        set_dma(1'b0, 16'h0000, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            set_cpu(1'b1, 16'h0300 + 16'(i), 8'($urandom), 1'b0);
            step(1'b1);
        end

        // Random traffic; each master holds its request until accepted
        for (int n = 0; n < 500; n++) begin
            if (!bus.cpu_req || last_rdy)
                set_cpu($urandom_range(0, 99) < 60, 16'h0300 | 16'($urandom_range(0, 15)),
                        8'($urandom), 1'($urandom_range(0, 1)));
            if (!bus.dma_req || last_gnt)
                set_dma($urandom_range(0, 99) < 45, 16'h0300 | 16'($urandom_range(0, 15)),
                        8'($urandom), 1'($urandom_range(0, 1)));
            step($urandom_range(0, 59) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
